ph_host_ctrl: RTL and testbench
===============================

# ph_host_ctrl

Host-side controller for the parasite-to-host register quad. It decodes host bus accesses and issues the one-hot select and pop strobes to the four PH registers. It assembles the status and data read bytes, holds the Tube control flags (T P V M J I Q), and generates the host IRQ, the FIFO-clear pulse, the parasite reset and the R3 one/two-byte mode select.

## Interface
Parameters:
- CLR_CYCLES, 4: cycles `h_fifo_clr` is held after T is set; range 1..15.
- RST_CYCLES, 8: minimum cycles `p_rst_out` is held after `h_rst_b` deasserts; range 1..255.

Ports:
- h_phi2  in  1  host clock; all state on rising edge.
- h_rst_b  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- h_cs  in  1  host access to Tube this cycle.
- h_rdnw  in  1  1 = read, 0 = write.
- h_addr  in  3  register address.
- h_din  in  8  host write data.
- h_ph_data  in  8  muxed PH register data (from quad).
- h_data_available  in  4  PH register n has data.
- h_hp_not_full  in  4  HP register n can accept a byte.
- h_selectData  out  4  one-hot PH register select.
- h_rd  out  1  pop strobe to PH quad.
- h_dout  out  8  host read data.
- h_irq_b  out  1  host IRQ, active low.
- h_fifo_clr  out  1  clear all FIFOs.
- p_rst_out  out  1  parasite reset, active high.
- one_byte_mode  out  1  R3 one-byte mode (= ~V).
- flags  out  7  {T,P,V,M,J,I,Q} to parasite side.

## Operation
- Address decode: odd address 2n+1 = data register n+1. Even address 2n = status register n+1.
- `h_selectData` is combinational: bit n = `h_cs & h_rdnw & (h_addr == 2n+1)`. It is 0 otherwise.
- `h_rd` is combinational, equal to `|h_selectData`. The quad pops at the end of the cycle.
- Reads of empty registers still pulse `h_rd`. Empty/underflow protection is the quad's job.
- `h_dout` is combinational:
  - data read: `h_ph_data`.
  - status n read: {`h_data_available[n]`, `h_hp_not_full[n]`, 6'b0}.
  - status 1 read: bits 5:0 = {P,V,M,J,I,Q}.
  - no read: 8'h00.
- Flag write: `h_cs & ~h_rdnw & h_addr==0`. For each bit i in 6:0 with `h_din[i]`=1, flag i <= `h_din[7]` (set/clear). Unselected flags are unchanged.
- Writes to other addresses are ignored here; they belong to the HP path.
- T set: start a counter at CLR_CYCLES. `h_fifo_clr`=1 while the counter is nonzero. When it reaches 0, T auto-clears.
- A T-set write while the counter is running reloads the counter. A T-clear write while it is running aborts it: T=0 and `h_fifo_clr`=0 next cycle.
- `p_rst_out` = P | (reset counter nonzero).
- `h_irq_b` is registered: `~(Q & h_data_available[3])`.
- `one_byte_mode` = ~V, combinational from the flag register.
- State machine for clear sequencing:
  - IDLE → CLEARING on a T-set write.
  - CLEARING → IDLE when the count reaches 1 (last cycle), or on a T-clear write.

## Timing
- Reset values:
  - flags = 7'b0.
  - `h_irq_b` = 1, `h_fifo_clr` = 0, `p_rst_out` = 1.
  - `one_byte_mode` = 1.
  - `h_rd` = 0, `h_selectData` = 0, `h_dout` = 0.
- Reset counter loads RST_CYCLES during reset. It decrements from the first edge after deassertion, so `p_rst_out` falls exactly RST_CYCLES edges after release (if P=0).
- Flag write effective on the next edge. The `flags` output and `one_byte_mode` update in the same cycle, post-edge.
- `h_fifo_clr` rises 1 edge after the T-set write and stays high for exactly CLR_CYCLES cycles.
- `h_irq_b` lags its inputs by 1 edge.
- Simultaneous data read and `h_fifo_clr`: the pop is still issued; the clear has priority in the quad.
- Reset asserted mid-CLEARING or mid-reset-count: all state returns to reset values immediately (asynchronously).

## Structure
- Shared package holds:
  - flag bit index constants (Q=0, I=1, J=2, M=3, V=4, P=5, T=6).
  - address constants.
  - clear-state encoding.
- One natural sub-module, `pulse_stretch`: a loadable down-counter with a busy output. It is instanced twice: once for the clear pulse (4-bit) and once for the reset hold (8-bit).

## Test plan
- Release reset, P=0 → `p_rst_out` high for exactly 8 cycles, then low. `one_byte_mode`=1 and `h_irq_b`=1 throughout.
- Write `h_addr`=0, `h_din`=8'h81 (set Q) with `h_data_available`=4'b1000 → `h_irq_b`=0 one edge later. Write 8'h01 (clear Q) → `h_irq_b`=1.
- Read `h_addr`=5 with `h_ph_data`=8'hA5 → `h_selectData`=4'b0100, `h_rd`=1, `h_dout`=8'hA5, all in the same cycle.
- Read `h_addr`=0 after writing 8'hBF then 8'h40 → `h_dout`[5:0]=6'h3F.
- Write 8'hC0 (set T) → `h_fifo_clr` high for exactly 4 cycles, then T reads back 0.
- Set T, then after 2 cycles write 8'h40 (clear T) → `h_fifo_clr`=0 on the next edge. Set V → `one_byte_mode`=0.

Source files
------------

// File: rtl/ph_host_ctrl_pkg.sv
// Shared definitions for the host-side PH register controller.
// This package holds the flag bit positions, the address map, the clear-sequencer
// state encoding and the status byte helper.
package ph_host_ctrl_pkg;

  localparam int FLAG_Q    = 0;
  localparam int FLAG_I    = 1;
  localparam int FLAG_J    = 2;
  localparam int FLAG_M    = 3;
  localparam int FLAG_V    = 4;
  localparam int FLAG_P    = 5;
  localparam int FLAG_T    = 6;
  localparam int NUM_FLAGS = 7;

  localparam logic [2:0] ADDR_FLAGS = 3'd0;

  typedef enum logic [0:0] {
    CLR_IDLE     = 1'b0,
    CLR_CLEARING = 1'b1
  } clr_state_e;

  function automatic logic [7:0] status_byte(input logic avail, input logic not_full,
                                             input logic [5:0] low_bits);
    return {avail, not_full, low_bits};
  endfunction

endpackage

// File: rtl/ph_host_ctrl_pulse_stretch.sv
// This is a loadable down-counter. The busy output is high while the count is nonzero.
// The last output flags the final busy cycle.
module pulse_stretch #(
  parameter int unsigned    W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         abort,
  output logic         busy,
  output logic         last
);

  logic [W-1:0] cnt_r;

  // Count register: load, abort, or decrement toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (abort) begin
      cnt_r <= '0;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != '0);
  assign last = (cnt_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ph_host_ctrl.sv
// This is the host-side controller for the parasite-to-host register quad.
// It handles decode, read mux, the Tube flags, IRQ, FIFO clear and parasite reset.
module ph_host_ctrl
  import ph_host_ctrl_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned RST_CYCLES = 8
) (
  input  logic       h_phi2,
  input  logic       h_rst_b,
  input  logic       h_cs,
  input  logic       h_rdnw,
  input  logic [2:0] h_addr,
  input  logic [7:0] h_din,
  input  logic [7:0] h_ph_data,
  input  logic [3:0] h_data_available,
  input  logic [3:0] h_hp_not_full,
  output logic [3:0] h_selectData,
  output logic       h_rd,
  output logic [7:0] h_dout,
  output logic       h_irq_b,
  output logic       h_fifo_clr,
  output logic       p_rst_out,
  output logic       one_byte_mode,
  output logic [6:0] flags
);

  logic [NUM_FLAGS-1:0] flags_r, flags_next_s;
  clr_state_e           clr_state_r;
  logic                 flag_wr_s, t_set_s, t_clr_s;
  logic                 clr_busy_s, clr_cnt_last_s, clr_last_s;
  logic                 rst_busy_s, rst_last_s;
  logic                 p_rst_r, irq_b_r;
  logic [3:0]           sel_s;
  logic [7:0]           dout_s;

  assign flag_wr_s  = h_cs & ~h_rdnw & (h_addr == ADDR_FLAGS);
  assign t_set_s    = flag_wr_s & h_din[FLAG_T] & h_din[7];
  assign t_clr_s    = flag_wr_s & h_din[FLAG_T] & ~h_din[7];
  assign clr_last_s = (clr_state_r == CLR_CLEARING) & clr_cnt_last_s;

  pulse_stretch #(.W(4), .RST_VAL(4'h0)) u_clr_stretch (
    .clk      (h_phi2),
    .rst_n    (h_rst_b),
    .load     (t_set_s),
    .load_val (4'(CLR_CYCLES)),
    .abort    (t_clr_s),
    .busy     (clr_busy_s),
    .last     (clr_cnt_last_s)
  );

  pulse_stretch #(.W(8), .RST_VAL(8'(RST_CYCLES))) u_rst_stretch (
    .clk      (h_phi2),
    .rst_n    (h_rst_b),
    .load     (1'b0),
    .load_val (8'h00),
    .abort    (1'b0),
    .busy     (rst_busy_s),
    .last     (rst_last_s)
  );

  // Next flag value: masked set/clear writes, then T auto-clear unless rewritten.
  always_comb begin
    flags_next_s = flags_r;
    if (flag_wr_s) begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (h_din[i]) begin
          flags_next_s[i] = h_din[7];
        end else begin
          flags_next_s[i] = flags_r[i];
        end
      end
    end else begin
      flags_next_s = flags_r;
    end
    if (clr_last_s && !(flag_wr_s && h_din[FLAG_T])) begin
      flags_next_s[FLAG_T] = 1'b0;
    end else begin
      flags_next_s[FLAG_T] = flags_next_s[FLAG_T];
    end
  end

  // Flag register, parasite reset and IRQ outputs.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      flags_r <= 7'b0;
      p_rst_r <= 1'b1;
      irq_b_r <= 1'b1;
    end else begin
      flags_r <= flags_next_s;
      // Mirror the next count state so the output stays in step with the counter.
      p_rst_r <= flags_next_s[FLAG_P] | (rst_busy_s & ~rst_last_s);
      irq_b_r <= ~(flags_r[FLAG_Q] & h_data_available[3]);
    end
  end

  // Clear sequencer: a T-set write (re)starts, and a T-clear write or the last count ends it.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      clr_state_r <= CLR_IDLE;
    end else begin
      case (clr_state_r)
        CLR_IDLE: begin
          if (t_set_s) clr_state_r <= CLR_CLEARING;
          else         clr_state_r <= CLR_IDLE;
        end
        CLR_CLEARING: begin
          if (t_set_s)                     clr_state_r <= CLR_CLEARING;
          else if (t_clr_s || clr_last_s) clr_state_r <= CLR_IDLE;
          else                             clr_state_r <= CLR_CLEARING;
        end
        default: clr_state_r <= CLR_IDLE;
      endcase
    end
  end

  // Read decode: odd addresses select data registers, and even addresses return status.
  always_comb begin
    sel_s  = 4'b0000;
    dout_s = 8'h00;
    if (h_cs && h_rdnw) begin
      if (h_addr[0]) begin
        sel_s[h_addr[2:1]] = 1'b1;
        dout_s             = h_ph_data;
      end else if (h_addr[2:1] == 2'd0) begin
        dout_s = status_byte(h_data_available[0], h_hp_not_full[0], flags_r[5:0]);
      end else begin
        dout_s = status_byte(h_data_available[h_addr[2:1]],
                             h_hp_not_full[h_addr[2:1]], 6'b000000);
      end
    end else begin
      sel_s  = 4'b0000;
      dout_s = 8'h00;
    end
  end

  assign h_selectData  = sel_s;
  assign h_rd          = |sel_s;
  assign h_dout        = dout_s;
  assign h_irq_b       = irq_b_r;
  assign h_fifo_clr    = clr_busy_s;
  assign p_rst_out     = p_rst_r;
  assign one_byte_mode = ~flags_r[FLAG_V];
  assign flags         = flags_r;

endmodule

// File: tb/tb_ph_host_ctrl.sv
// This is a scoreboard bench for ph_host_ctrl.
// Expected values are queued as stimulus is driven and compared once the DUT responds.
module tb_ph_host_ctrl;

  localparam int S_DOUT = 0, S_SEL = 1, S_RD = 2, S_IRQ = 3, S_CLR = 4,
                 S_PRST = 5, S_OBM = 6, S_FLAGS = 7;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] exp;
  } sb_item_t;

  logic       h_phi2 = 1'b0;
  logic       h_rst_b, h_cs, h_rdnw;
  logic [2:0] h_addr;
  logic [7:0] h_din, h_ph_data;
  logic [3:0] h_data_available, h_hp_not_full;
  logic [3:0] h_selectData;
  logic       h_rd, h_irq_b, h_fifo_clr, p_rst_out, one_byte_mode;
  logic [7:0] h_dout;
  logic [6:0] flags;

  sb_item_t   sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [6:0] fl_model = 7'b0;

  ph_host_ctrl #(.CLR_CYCLES(4), .RST_CYCLES(8)) dut (
    .h_phi2(h_phi2), .h_rst_b(h_rst_b), .h_cs(h_cs), .h_rdnw(h_rdnw),
    .h_addr(h_addr), .h_din(h_din), .h_ph_data(h_ph_data),
    .h_data_available(h_data_available), .h_hp_not_full(h_hp_not_full),
    .h_selectData(h_selectData), .h_rd(h_rd), .h_dout(h_dout),
    .h_irq_b(h_irq_b), .h_fifo_clr(h_fifo_clr), .p_rst_out(p_rst_out),
    .one_byte_mode(one_byte_mode), .flags(flags)
  );

  always #5 h_phi2 = ~h_phi2;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] observe(input int s);
    case (s)
      S_DOUT:  return h_dout;
      S_SEL:   return {4'b0000, h_selectData};
      S_RD:    return {7'b0, h_rd};
      S_IRQ:   return {7'b0, h_irq_b};
      S_CLR:   return {7'b0, h_fifo_clr};
      S_PRST:  return {7'b0, p_rst_out};
      S_OBM:   return {7'b0, one_byte_mode};
      S_FLAGS: return {1'b0, flags};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push(input string tag, input int s, input logic [7:0] exp);
    sb_item_t it;
    it.tag = tag; it.sig = s; it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_val(it.tag, observe(it.sig), it.exp);
    end
  endtask

  task automatic tick();
    @(posedge h_phi2);
    #1;
  endtask

  task automatic flag_write(input logic [7:0] d);
    h_cs = 1'b1; h_rdnw = 1'b0; h_addr = 3'd0; h_din = d;
    tick();
    h_cs = 1'b0;
    for (int i = 0; i < 7; i++) if (d[i]) fl_model[i] = d[7];
  endtask

  task automatic reset_checks(input string tag);
    push({tag, "_flags"}, S_FLAGS, 8'h00);
    push({tag, "_irq"},   S_IRQ,   8'h01);
    push({tag, "_clr"},   S_CLR,   8'h00);
    push({tag, "_prst"},  S_PRST,  8'h01);
    push({tag, "_obm"},   S_OBM,   8'h01);
    push({tag, "_rd"},    S_RD,    8'h00);
    push({tag, "_sel"},   S_SEL,   8'h00);
    push({tag, "_dout"},  S_DOUT,  8'h00);
    drain();
  endtask

  task automatic reset_release_seq(input string tag);
    for (int k = 1; k <= 10; k++) begin
      tick();
      push({tag, "_prst"}, S_PRST, (k < 8) ? 8'h01 : 8'h00);
      push({tag, "_obm"},  S_OBM,  8'h01);
      push({tag, "_irq"},  S_IRQ,  8'h01);
      drain();
    end
  endtask

  initial begin
    logic [7:0] exp_d;
    h_rst_b = 1'b0; h_cs = 1'b0; h_rdnw = 1'b1; h_addr = 3'd0; h_din = 8'h00;
    h_ph_data = 8'h00; h_data_available = 4'b0000; h_hp_not_full = 4'b0000;

    #12;
    reset_checks("rst");
    #8 h_rst_b = 1'b1;
    reset_release_seq("rel");

    // IRQ follows Q & data_available[3] with one edge of lag.
    h_data_available = 4'b1000;
    flag_write(8'h81);
    push("q_set_flags", S_FLAGS, {1'b0, fl_model}); drain();
    tick();
    push("irq_low", S_IRQ, 8'h00); drain();
    h_data_available = 4'b0000; #1;
    push("irq_lag", S_IRQ, 8'h00); drain();
    tick();
    push("irq_avail_gone", S_IRQ, 8'h01); drain();
    h_data_available = 4'b1000;
    tick();
    push("irq_low2", S_IRQ, 8'h00); drain();
    flag_write(8'h01);
    tick();
    push("irq_q_clr", S_IRQ, 8'h01); drain();

    // Data read of register 3 this cycle.
    h_cs = 1'b1; h_rdnw = 1'b1; h_addr = 3'd5; h_ph_data = 8'hA5; #1;
    push("rd5_sel", S_SEL, 8'h04); push("rd5_rd", S_RD, 8'h01);
    push("rd5_dout", S_DOUT, 8'hA5); drain();

    // Sweep all addresses with random quad state.
    flag_write(8'hBF);
    flag_write(8'h40);
    for (int a = 0; a < 8; a++) begin
      h_cs = 1'b1; h_rdnw = 1'b1; h_addr = 3'(a);
      h_ph_data = 8'($urandom); h_data_available = 4'($urandom); h_hp_not_full = 4'($urandom);
      #1;
      if (a % 2 == 1) begin
        push("sw_sel", S_SEL, 8'h01 << (a / 2)); push("sw_rd", S_RD, 8'h01);
        push("sw_dout", S_DOUT, h_ph_data);
      end else begin
        exp_d = {h_data_available[a / 2], h_hp_not_full[a / 2], 6'b0};
        if (a == 0) exp_d[5:0] = fl_model[5:0];
        push("sw_sel", S_SEL, 8'h00); push("sw_rd", S_RD, 8'h00);
        push("sw_dout", S_DOUT, exp_d);
      end
      drain();
    end
    h_addr = 3'd0; h_data_available = 4'b0000; h_hp_not_full = 4'b0000; #1;
    push("st1_low6", S_DOUT, 8'h3F); drain();
    h_cs = 1'b0; #1;
    push("noacc_dout", S_DOUT, 8'h00); push("noacc_rd", S_RD, 8'h00); drain();
    h_cs = 1'b1; h_rdnw = 1'b0; h_addr = 3'd3; #1;
    push("wr3_sel", S_SEL, 8'h00); push("wr3_dout", S_DOUT, 8'h00); drain();
    h_cs = 1'b0;
    push("p_hold", S_PRST, 8'h01); drain();
    flag_write(8'h3F);
    push("flags_clr6", S_FLAGS, {1'b0, fl_model}); push("p_rel", S_PRST, 8'h00);
    push("obm_back", S_OBM, 8'h01); drain();

    // T set: clear pulse of exactly four cycles, then T self-clears.
    flag_write(8'hC0);
    for (int k = 0; k < 6; k++) begin
      push("tset_clr", S_CLR, (k < 4) ? 8'h01 : 8'h00);
      push("tset_t", S_FLAGS, (k < 4) ? 8'h40 : 8'h00);
      if (k == 1) begin
        h_cs = 1'b1; h_rdnw = 1'b1; h_addr = 3'd1; #1;
        push("pop_during_clr", S_RD, 8'h01);
      end
      drain();
      h_cs = 1'b0;
      tick();
    end
    fl_model[6] = 1'b0;

    // Reload while running extends the pulse.
    flag_write(8'hC0);
    tick();
    flag_write(8'hC0);
    for (int k = 0; k < 5; k++) begin
      push("reload_clr", S_CLR, (k < 4) ? 8'h01 : 8'h00); drain();
      tick();
    end

    // Abort with a T-clear write.
    flag_write(8'hC0);
    tick(); tick();
    flag_write(8'h40);
    push("abort_clr", S_CLR, 8'h00); push("abort_t", S_FLAGS, 8'h00); drain();
    tick();
    push("abort_stay", S_CLR, 8'h00); drain();

    flag_write(8'h90);
    push("v_obm", S_OBM, 8'h00); push("v_flags", S_FLAGS, 8'h10); drain();

    // Async reset in the middle of a clear sequence.
    flag_write(8'hC0);
    tick();
    #3 h_rst_b = 1'b0;
    #1;
    reset_checks("arst");
    fl_model = 7'b0;
    #1 h_rst_b = 1'b1;
    reset_release_seq("rel2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
